// File: rtl/ndata_width_downsizer.sv
// Splits each wide input beat into IN_WIDTH/OUT_WIDTH narrow chunks, skipping
// chunks whose keep bits are all zero so the narrow side never idles on empty data.
module ndata_width_downsizer #(
    parameter int ELEM_WIDTH = 8,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [IN_WIDTH*ELEM_WIDTH-1:0]  in_data,
    input  logic [IN_WIDTH-1:0]             in_keep,
    input  logic                            in_last,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [OUT_WIDTH*ELEM_WIDTH-1:0] out_data,
    output logic [OUT_WIDTH-1:0]            out_keep,
    output logic                            out_last,
    output logic                            out_valid,
    input  logic                            out_ready
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW    = OUT_WIDTH * ELEM_WIDTH;

    generate
        if ((OUT_WIDTH > IN_WIDTH) || (IN_WIDTH % OUT_WIDTH != 0)) begin : g_bad_ratio
            $error("ndata_width_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH");
        end
    endgenerate

    logic [IN_WIDTH*ELEM_WIDTH-1:0] buf_data;
    logic [IN_WIDTH-1:0]            buf_keep;
    logic                           buf_last;
    logic                           buf_valid;
    logic [IDX_W-1:0]               idx;

    logic [RATIO-1:0] buf_nz;
    logic [RATIO-1:0] in_nz;
    logic             is_final;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] first_idx;
    logic             out_fire;
    logic             in_fire;
    logic             load_beat;

    always_comb begin
        buf_nz = '0;
        in_nz  = '0;
        for (int k = 0; k < RATIO; k++) begin
            buf_nz[k] = |buf_keep[k*OUT_WIDTH +: OUT_WIDTH];
            in_nz[k]  = |in_keep[k*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    // Downward scan: the last hit is the lowest qualifying chunk, so the
    // skip over any run of empty chunks resolves in a single cycle.
    always_comb begin
        is_final  = 1'b1;
        next_idx  = idx;
        first_idx = '0;
        for (int k = RATIO - 1; k >= 0; k--) begin
            if (buf_nz[k] && (k > int'(idx))) begin
                is_final = 1'b0;
                next_idx = IDX_W'(k);
            end
            if (in_nz[k]) begin
                first_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        out_data = '0;
        out_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == IDX_W'(k)) begin
                out_data = buf_data[k*CW +: CW];
                out_keep = buf_keep[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and a held beat stays stable.
    assign out_valid = buf_valid;
    assign out_last  = buf_valid & buf_last & is_final;
    assign out_fire  = buf_valid & out_ready;
    assign in_ready  = ~buf_valid | (out_fire & is_final);
    assign in_fire   = in_valid & in_ready;
    // An all-empty beat is dropped unless it closes a frame.
    assign load_beat = in_fire & ((|in_keep) | in_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            idx       <= '0;
        end else if (in_fire) begin
            buf_valid <= load_beat;
            idx       <= load_beat ? first_idx : '0;
        end else if (out_fire) begin
            if (is_final) begin
                buf_valid <= 1'b0;
            end else begin
                idx <= next_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_beat) begin
            buf_data <= in_data;
            buf_keep <= in_keep;
            buf_last <= in_last;
        end
    end

endmodule

// File: tb/tb_ndata_width_downsizer.sv
// Directed tables, hand sequences and a random stalled stream for the
// keep-aware width downsizer (16->8 and 32->8 element configurations).
module tb_ndata_width_downsizer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] a_in_data;
    logic [15:0]  a_in_keep;
    logic         a_in_last, a_in_valid, a_in_ready;
    logic [63:0]  a_out_data;
    logic [7:0]   a_out_keep;
    logic         a_out_last, a_out_valid, a_out_ready;

    logic [255:0] b_in_data;
    logic [31:0]  b_in_keep;
    logic         b_in_last, b_in_valid, b_in_ready;
    logic [63:0]  b_out_data;
    logic [7:0]   b_out_keep;
    logic         b_out_last, b_out_valid, b_out_ready;

    ndata_width_downsizer #(.ELEM_WIDTH(8), .IN_WIDTH(16), .OUT_WIDTH(8)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_keep(a_in_keep), .in_last(a_in_last),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_keep(a_out_keep), .out_last(a_out_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    ndata_width_downsizer #(.ELEM_WIDTH(8), .IN_WIDTH(32), .OUT_WIDTH(8)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_keep(b_in_keep), .in_last(b_in_last),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_keep(b_out_keep), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pat(input logic [7:0] base);
        logic [255:0] d;
        for (int i = 0; i < 32; i++) d[i*8 +: 8] = base + 8'(i);
        return d;
    endfunction

    function automatic logic [63:0] chunk(input logic [255:0] d, input int c);
        return d[c*64 +: 64];
    endfunction

    typedef struct {
        logic [31:0] keep;
        logic        last;
        logic [3:0]  exp_mask;  // chunks expected on out, emitted in ascending order
    } vec_t;

    vec_t vecs[8];

    logic [72:0] exp_q[$];

    task automatic model_push(input logic [255:0] d, input logic [31:0] k, input logic l);
        int last_c = -1;
        for (int c = 0; c < 4; c++) if (|k[c*8 +: 8]) last_c = c;
        if (last_c < 0) begin
            if (l) exp_q.push_back({d[63:0], 8'h00, 1'b1});
        end else begin
            for (int c = 0; c < 4; c++)
                if (|k[c*8 +: 8]) exp_q.push_back({chunk(d, c), k[c*8 +: 8], l && (c == last_c)});
        end
    endtask

    initial begin
        logic [255:0] dat, da, db, r_d, dr;
        logic [31:0]  r_k;
        logic         r_l, have, stalled;
        logic [72:0]  saved, got, expv;
        int           lows, sent, cyc, ci;
        int           mode;

        vecs[0] = '{32'hFFFF_FFFF, 1'b1, 4'b1111};
        vecs[1] = '{32'h00FF_00F0, 1'b1, 4'b0101};
        vecs[2] = '{32'h0000_0000, 1'b1, 4'b0001};
        vecs[3] = '{32'h0000_0000, 1'b0, 4'b0000};
        vecs[4] = '{32'hFF00_0000, 1'b0, 4'b1000};
        vecs[5] = '{32'h0000_FF00, 1'b1, 4'b0010};
        vecs[6] = '{32'h8000_0001, 1'b1, 4'b1001};
        vecs[7] = '{32'h00F0_0000, 1'b1, 4'b0100};

        a_in_data = '0; a_in_keep = '0; a_in_last = 0; a_in_valid = 0; a_out_ready = 0;
        b_in_data = '0; b_in_keep = '0; b_in_last = 0; b_in_valid = 0; b_out_ready = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_valid_last_ready", {a_out_valid, a_out_last, a_in_ready}, 3'b001);
        check("rst_b_valid_last_ready", {b_out_valid, b_out_last, b_in_ready}, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 16->8 full beat: two chunks, in_ready low for exactly one cycle
        da = pat(8'h00);
        a_in_data = da[127:0]; a_in_keep = 16'hFFFF; a_in_last = 1; a_in_valid = 1; a_out_ready = 1;
        #1 check("s1_ready_idle", a_in_ready, 1'b1);
        @(posedge clk); #1; a_in_valid = 0; #1;
        lows = 0;
        check("s1_beat0", {a_out_valid, a_out_data, a_out_keep, a_out_last}, {1'b1, 64'h0706050403020100, 8'hFF, 1'b0});
        lows += int'(!a_in_ready);
        @(posedge clk); #2;
        check("s1_beat1", {a_out_valid, a_out_data, a_out_keep, a_out_last}, {1'b1, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1});
        lows += int'(!a_in_ready);
        @(posedge clk); #2;
        check("s1_after", a_out_valid, 1'b0);
        lows += int'(!a_in_ready);
        check("s1_ready_low_cycles", lows, 1);

        // 16->8 back-to-back A, B
        da = pat(8'h10); db = pat(8'h40);
        @(posedge clk); #1;
        a_in_data = da[127:0]; a_in_keep = 16'hFFFF; a_in_last = 1; a_in_valid = 1;
        @(posedge clk); #1;
        a_in_data = db[127:0];
        #1 check("b2b_a0", {a_out_valid, a_out_data, a_out_keep, a_in_ready}, {1'b1, chunk(da, 0), 8'hFF, 1'b0});
        @(posedge clk); #2;
        check("b2b_a1", {a_out_valid, a_out_data, a_out_last, a_in_ready}, {1'b1, chunk(da, 1), 1'b1, 1'b1});
        @(posedge clk); #1; a_in_valid = 0; #1;
        check("b2b_b0", {a_out_valid, a_out_data, a_out_last}, {1'b1, chunk(db, 0), 1'b0});
        @(posedge clk); #2;
        check("b2b_b1", {a_out_valid, a_out_data, a_out_last}, {1'b1, chunk(db, 1), 1'b1});
        @(posedge clk); #2;
        check("b2b_idle", a_out_valid, 1'b0);

        // 16->8 empty beats: no-last dropped, last emits one empty beat
        @(posedge clk); #1;
        a_in_keep = 16'h0000; a_in_last = 0; a_in_valid = 1;
        @(posedge clk); #1;
        a_in_last = 1;
        #1 check("zero_nolast", {a_out_valid, a_in_ready}, 2'b01);
        @(posedge clk); #1; a_in_valid = 0; #1;
        check("zero_last", {a_out_valid, a_out_keep, a_out_last}, {1'b1, 8'h00, 1'b1});
        @(posedge clk); #2;
        check("zero_idle", a_out_valid, 1'b0);

        // 32->8 table
        @(posedge clk); #1;
        for (int v = 0; v < 8; v++) begin
            dat = pat(8'(8'h20 + v));
            b_in_data = dat; b_in_keep = vecs[v].keep; b_in_last = vecs[v].last;
            b_in_valid = 1; b_out_ready = 1;
            #1 check("tbl_in_ready", b_in_ready, 1'b1);
            @(posedge clk); #1; b_in_valid = 0; #1;
            for (int c = 0; c < 4; c++) begin
                if (vecs[v].exp_mask[c]) begin
                    check("tbl_beat", {b_out_valid, b_out_data, b_out_keep, b_out_last},
                          {1'b1, chunk(dat, c), vecs[v].keep[c*8 +: 8],
                           vecs[v].last && ((vecs[v].exp_mask >> (c + 1)) == 4'b0)});
                    @(posedge clk); #2;
                end
            end
            check("tbl_idle", {b_out_valid, b_in_ready}, 2'b01);
            #(-1 + 1);
        end

        // 32->8 random stream with random back-pressure
        @(posedge clk); #1;
        have = 0; sent = 0; cyc = 0; stalled = 0; saved = '0;
        r_d = '0; r_k = '0; r_l = 0;
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            if (!have && sent < 1000 && $urandom_range(0, 3) != 0) begin
                for (int j = 0; j < 8; j++) r_d[j*32 +: 32] = $urandom();
                mode = $urandom_range(0, 3);
                r_k = $urandom();
                if (mode == 0) r_k = 32'hFFFF_FFFF;
                if (mode == 1 || mode == 3)
                    for (int c = 0; c < 4; c++)
                        if ($urandom_range(0, 1) == 0) r_k[c*8 +: 8] = 8'h00;
                        else if (mode == 1) r_k[c*8 +: 8] = 8'hFF;
                r_l = ($urandom_range(0, 2) == 0);
                have = 1;
            end
            b_in_valid = have; b_in_data = r_d; b_in_keep = r_k; b_in_last = r_l;
            b_out_ready = 1'($urandom_range(0, 1));
            #1;
            got = {b_out_data, b_out_keep, b_out_last};
            if (stalled) check("rand_stall_hold", {b_out_valid, got}, {1'b1, saved});
            if (b_out_valid && b_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_extra_beat", {b_out_valid, got}, 74'd0);
                end else begin
                    expv = exp_q.pop_front();
                    check("rand_beat", got, expv);
                end
            end
            stalled = b_out_valid && !b_out_ready;
            saved = got;
            if (b_in_valid && b_in_ready) begin
                model_push(r_d, r_k, r_l);
                have = 0;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        b_in_valid = 0; b_out_ready = 1;
        check("rand_sent", sent, 1000);
        check("rand_drain", exp_q.size(), 0);

        // Reset while chunk 1 of 4 is pending
        repeat (2) @(posedge clk);
        #1;
        dr = pat(8'h80);
        b_in_data = dr; b_in_keep = 32'hFFFF_FFFF; b_in_last = 1; b_in_valid = 1; b_out_ready = 0;
        @(posedge clk); #1; b_in_valid = 0; b_out_ready = 1; #1;
        check("rst_seq_chunk0", {b_out_valid, b_out_data}, {1'b1, chunk(dr, 0)});
        @(posedge clk); #1; b_out_ready = 0; #1;
        check("rst_seq_chunk1", {b_out_valid, b_out_data, b_out_last}, {1'b1, chunk(dr, 1), 1'b0});
        #2 rst_n = 1'b0;
        #1 check("rst_async_drop", {b_out_valid, b_out_last, b_in_ready}, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;
        b_out_ready = 1;
        @(posedge clk); #2;
        check("rst_release_idle", {b_out_valid, b_in_ready}, 2'b01);
        dr = pat(8'h90);
        b_in_data = dr; b_in_keep = 32'h0000_FF00; b_in_last = 1; b_in_valid = 1;
        @(posedge clk); #1; b_in_valid = 0; #1;
        check("rst_next_beat", {b_out_valid, b_out_data, b_out_keep, b_out_last},
              {1'b1, chunk(dr, 1), 8'hFF, 1'b1});
        @(posedge clk); #2;
        check("rst_next_done", {b_out_valid, b_in_ready}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ndata_width_downsizer.md
# ndata_width_downsizer

Splits each beat of a wide `ndata_i` stream into `RATIO = IN_WIDTH / OUT_WIDTH` narrow beats for any integer ratio. It is the general-ratio, keep-aware narrowing counterpart to the stream up-sizing path. Chunks whose keep bits are all zero are skipped, so a narrow consumer never spends a cycle on an empty chunk. It sits between wide producers (memory/network datapaths) and narrow operators in the stream library.

## Interface
- `data_t`, no default: element type carried on both sides.
- `IN_WIDTH`, derived from `in.NUM_ELEMENTS`: elements per input beat.
- `OUT_WIDTH`, derived from `out.NUM_ELEMENTS`: elements per output beat.
- `RATIO`, localparam = `IN_WIDTH / OUT_WIDTH`.
  - Elaboration `$error` if `IN_WIDTH % OUT_WIDTH != 0` or `OUT_WIDTH > IN_WIDTH`.
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in`  `ndata_i.s`  `IN_WIDTH x data_t` data, `IN_WIDTH` keep, 1 last, 1 valid, 1 ready: wide input.
- `out`  `ndata_i.m`  `OUT_WIDTH x data_t` data, `OUT_WIDTH` keep, 1 last, 1 valid, 1 ready: narrow output.

## Operation
- Holds one input beat in a buffer: `buf_data`, `buf_keep`, `buf_last`, `buf_valid`, plus chunk index `idx` (`$clog2(RATIO)` bits, min 1).
- Chunk k = elements `[k*OUT_WIDTH +: OUT_WIDTH]`. A chunk is non-empty if any of its keep bits is 1.
- `final` = no non-empty chunk with index > `idx` in `buf_keep`.
- Outputs:
  - `out.valid = buf_valid`
  - `out.data` = chunk `idx` of `buf_data`
  - `out.keep` = chunk `idx` of `buf_keep`
  - `out.last = buf_valid & buf_last & final`
- `in.ready = !buf_valid | (out.valid & out.ready & final)`.
- Input accept (`in.valid & in.ready`):
  - Load the buffer.
  - `idx` = lowest non-empty chunk index.
  - Set `buf_valid = 1`.
- Output handshake with `!final`: `idx` jumps to the next non-empty chunk, skipping empty ones, in a single cycle.
- Output handshake with `final` and no simultaneous accept: `buf_valid = 0`.
- Output handshake with `final` and simultaneous accept: the new beat loads the same cycle, giving a seamless stream.
- All-zero keep input beat:
  - `last = 0`: consumed, `buf_valid` stays/becomes 0, nothing emitted.
  - `last = 1`: loaded with `idx = 0`; emits one beat with keep `0`, last `1`, so frame boundaries are preserved.
- Keep holes inside a chunk are passed through unmodified. No compaction within a chunk.
- `RATIO == 1`: same logic, acting as a one-beat register stage.
- Data/keep bits outside the emitted chunk are never visible on `out`.

## Timing
- Reset (async assert, sync-released use):
  - `buf_valid = 0`, `idx = 0`, so `out.valid = 0`, `out.last = 0`, `in.ready = 1`.
  - `buf_data`/`buf_keep` are not reset; `out.data` and `out.keep` are don't-care while `out.valid = 0`.
- Reset asserted mid-beat: the buffered beat and its remaining chunks are discarded; nothing is emitted after release until a new accept.
- Latency: input accept at cycle t gives `out.valid` at t+1.
- Throughput: one output beat per cycle while `out.ready = 1`.
  - A full beat takes exactly `RATIO` cycles.
  - A beat with n non-empty chunks takes n cycles; an all-zero `last` beat takes 1 cycle.
  - No bubble between consecutive input beats.
- `out.ready = 0`: `out.data`, `out.keep`, `out.last` held stable, `out.valid` stays 1.
- `in.ready` is combinational from `out.ready`.
- `out.valid` never depends combinationally on `in.valid`.
- `in.valid` may be asserted with `in.ready = 0`; the beat is held by the producer per the protocol.

## Test plan
- IN=16, OUT=8, keep `FFFF`, data `0x0F..0x00`, last 1, `out.ready = 1` → two beats:
  - data `07..00`, keep `FF`, last 0
  - data `0F..08`, keep `FF`, last 1
  - `in.ready` low for exactly 1 cycle.
- IN=32, OUT=8, keep `0x00FF00F0`, last 1 → two beats: chunk0 keep `F0`, last 0; chunk2 keep `FF`, last 1. Chunks 1 and 3 are skipped with no idle cycle.
- IN=16, OUT=8, back-to-back beats A, B (keep `FFFF`), `out.ready = 1` → output A0, A1, B0, B1 on 4 consecutive cycles; B accepted on the cycle A1 handshakes.
- IN=16, OUT=8, beat keep `0000` last 0, then keep `0000` last 1 → first produces no output; second produces one beat with keep `00`, last 1.
- `out.ready` random 50% toggling over 1000 random beats/keeps → output matches a reference model chunk-for-chunk. Outputs are stable while stalled and no beat is lost or duplicated.
- Assert `rst_n = 0` asynchronously while chunk 1 of 4 is pending → `out.valid` drops immediately. After release, `in.ready = 1` and the next beat emits starting from its first non-empty chunk.
